// File: rtl/branch_predictor_pkg.sv
// Shared encodings and helpers for the branch direction predictor.
// Every 2-bit counter in the table is stepped by sat_step.
package branch_predictor_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  // One training step: move toward the resolved direction, clamped at the strong states.
  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic up);
    logic [1:0] n;
    n = s;
    if (up && (s != BP_ST))
      n = s + 2'd1;
    else if (!up && (s != BP_SNT))
      n = s - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// A 2-bit saturating up/down counter, which is one entry of the direction table.
// The count steps only when en is high, and a synchronous reset loads RESET_VAL.
module sat_counter2
  import branch_predictor_pkg::*;
#(
  parameter logic [1:0] RESET_VAL = BP_WNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  output logic [1:0] state
);

  always_ff @(posedge clk) begin
    if (rst)
      state <= RESET_VAL;
    else if (en)
      state <= sat_step(state, up);
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal or gshare direction predictor built from flop-based 2-bit counters.
// The predictor trains on the outcome of each branch after it resolves, and it counts branches and mispredicts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         ENTRIES    = 32,
  parameter int         HIST_BITS  = 0,
  parameter logic [1:0] INIT_STATE = BP_WNT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            lk_pc,
  input  logic                                   lk_valid,
  output logic                                   lk_taken,
  input  logic                                   upd_valid,
  input  logic [31:0]                            upd_pc,
  input  logic                                   upd_pred,
  input  logic                                   upd_suc,
  output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] ghr,
  output logic [31:0]                            br_count,
  output logic [31:0]                            mispred_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [GW-1:0] ghr_q;
  logic [GW:0]   ghr_shift;
  logic [IW-1:0] hist_x;
  logic [IW-1:0] lk_idx;
  logic [IW-1:0] upd_idx;
  logic          act;
  logic [1:0]    ctr [ENTRIES];
  logic          unused_pc_bits;

  assign act = upd_suc ? upd_pred : ~upd_pred;

  // History is folded into the low index bits. In bimodal mode it stays zero.
  always_comb begin
    hist_x = '0;
    if (HIST_BITS > 0)
      hist_x[GW-1:0] = ghr_q;
  end

  assign lk_idx  = lk_pc[IW+1:2]  ^ hist_x;
  assign upd_idx = upd_pc[IW+1:2] ^ hist_x;

  assign unused_pc_bits = ^{lk_pc[31:IW+2], lk_pc[1:0], upd_pc[31:IW+2], upd_pc[1:0]};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    sat_counter2 #(.RESET_VAL(INIT_STATE)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (upd_valid && (upd_idx == IW'(i))),
      .up    (act),
      .state (ctr[i])
    );
  end

  // A lookup reads the counter as it was before any update in the same cycle.
  assign lk_taken = lk_valid & ctr[lk_idx][1];

  assign ghr_shift = {ghr_q, act};

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q         <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd_valid) begin
      if (HIST_BITS > 0)
        ghr_q <= ghr_shift[GW-1:0];
      br_count <= br_count + 32'd1;
      if (!upd_suc)
        mispred_count <= mispred_count + 32'd1;
    end
  end

  assign ghr = ghr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Drives a bimodal predictor and a gshare predictor (HIST_BITS=4) with the same stimulus.
// Each predictor is checked against an array-based model of counters and history.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc;
  logic        lk_valid;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_pred;
  logic        upd_suc;

  logic        lk_bi, lk_gs;
  logic        ghr_bi;
  logic [3:0]  ghr_gs;
  logic [31:0] br_bi, br_gs, mis_bi, mis_gs;

  int n_tests = 0;
  int n_fail  = 0;

  int          tbl_bi [32];
  int          tbl_gs [32];
  int          ghr_m;
  logic [31:0] br_m, mis_m;
  logic        pre_bi, pre_gs;

  always #5 clk = ~clk;

  branch_predictor dut_bi (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_valid(lk_valid), .lk_taken(lk_bi),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pred(upd_pred), .upd_suc(upd_suc),
    .ghr(ghr_bi), .br_count(br_bi), .mispred_count(mis_bi)
  );

  branch_predictor #(.HIST_BITS(4)) dut_gs (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_valid(lk_valid), .lk_taken(lk_gs),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pred(upd_pred), .upd_suc(upd_suc),
    .ghr(ghr_gs), .br_count(br_gs), .mispred_count(mis_gs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx_bi(input logic [31:0] pc);
    return (pc / 4) % 32;
  endfunction

  function automatic int idx_gs(input logic [31:0] pc);
    return ((pc / 4) % 32) ^ (ghr_m % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      tbl_bi[i] = 1;
      tbl_gs[i] = 1;
    end
    ghr_m = 0;
    br_m  = 0;
    mis_m = 0;
  endtask

  // One clock cycle. The bench checks lookups before the edge and checks architectural state after it.
  task automatic cyc(input logic r, input logic lv, input logic [31:0] lpc,
                     input logic uv, input logic [31:0] upc, input logic pr, input logic sc);
    int ib, ig;
    bit a;
    rst = r; lk_valid = lv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_pred = pr; upd_suc = sc;
    #1;
    pre_bi = lk_bi;
    pre_gs = lk_gs;
    chk("lk_bi_model", {31'd0, lk_bi}, {31'd0, lv && tbl_bi[idx_bi(lpc)] >= 2});
    chk("lk_gs_model", {31'd0, lk_gs}, {31'd0, lv && tbl_gs[idx_gs(lpc)] >= 2});
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (uv) begin
      a  = sc ? pr : !pr;
      ib = idx_bi(upc);
      ig = idx_gs(upc);
      if (a) begin
        if (tbl_bi[ib] < 3) tbl_bi[ib]++;
        if (tbl_gs[ig] < 3) tbl_gs[ig]++;
      end else begin
        if (tbl_bi[ib] > 0) tbl_bi[ib]--;
        if (tbl_gs[ig] > 0) tbl_gs[ig]--;
      end
      ghr_m = ((ghr_m * 2) + int'(a)) % 16;
      br_m  = br_m + 1;
      if (!sc) mis_m = mis_m + 1;
    end
    #1;
    chk("br_bi",  br_bi,  br_m);
    chk("br_gs",  br_gs,  br_m);
    chk("mis_bi", mis_bi, mis_m);
    chk("mis_gs", mis_gs, mis_m);
    chk("ghr_bi", {31'd0, ghr_bi}, 32'd0);
    chk("ghr_gs", {28'd0, ghr_gs}, ghr_m);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1'b0, 1'b1, pc, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic pr, input logic sc);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, pc, pr, sc);
  endtask

  initial begin
    model_reset();
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    look(32'h100);
    chk("reset_lk", {31'd0, pre_bi}, 32'd0);
    chk("reset_br", br_bi, 32'd0);
    chk("reset_mis", mis_bi, 32'd0);
    chk("reset_ghr", {28'd0, ghr_gs}, 32'd0);

    // Train upward with actual taken outcomes, then apply one not-taken outcome.
    upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b0, 1'b0);
    look(32'h100);
    chk("train_up_lk", {31'd0, pre_bi}, 32'd1);
    upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    look(32'h100);
    chk("st_to_wt_lk", {31'd0, pre_bi}, 32'd1);
    chk("four_br", br_bi, 32'd4);
    chk("four_mis", mis_bi, 32'd4);

    // 0x200 shares index 0 with 0x100. Drive the counter down to 00 and check that it holds there.
    for (int i = 0; i < 5; i++) upd(32'h200, 1'b0, 1'b1);
    upd(32'h200, 1'b0, 1'b0);
    look(32'h200);
    chk("sat_bottom_lk", {31'd0, pre_bi}, 32'd0);

    upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b0, 1'b0);
    look(32'h180);
    chk("alias_lk", {31'd0, pre_bi}, 32'd1);
    look(32'h104);
    chk("nonalias_lk", {31'd0, pre_bi}, 32'd0);

    // Lookup and update in the same cycle: the lookup sees the counter before the update.
    cyc(1'b0, 1'b1, 32'h308, 1'b1, 32'h308, 1'b0, 1'b0);
    chk("same_cyc_lk", {31'd0, pre_bi}, 32'd0);
    look(32'h308);
    chk("next_cyc_lk", {31'd0, pre_bi}, 32'd1);

    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    upd(32'h040, 1'b1, 1'b1);
    upd(32'h044, 1'b1, 1'b0);
    upd(32'h048, 1'b0, 1'b0);
    upd(32'h04c, 1'b1, 1'b1);
    chk("ghr_1011", {28'd0, ghr_gs}, 32'hb);
    cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h040, 1'b0, 1'b0);
    chk("rst_upd_br", br_gs, 32'd0);
    chk("rst_upd_ghr", {28'd0, ghr_gs}, 32'd0);
    look(32'h040);
    chk("rst_upd_lk", {31'd0, pre_gs}, 32'd0);

    for (int n = 0; n < 2000; n++) begin
      cyc(($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)),
          {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
          ($urandom_range(0, 3) != 0),
          {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
